// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver.
// The asynchronous RX line is synchronised, bits are timed from a
// programmable prescaler, and each bit is decided by a 3-sample majority vote
// taken around the middle of the bit. The block supports even, odd or no
// parity, and one or two stop bits. Parity, framing and overrun errors are
// reported as separate sticky flags.
module uart_rx_os #(
  parameter int WORD_LENGHT = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX_in,
  input  logic [DIV_WIDTH-1:0]   baud_div,
  input  logic [1:0]             parity_mode,
  input  logic                   two_stop,
  input  logic                   clear_interrupt,
  output logic [WORD_LENGHT-1:0] RX_out,
  output logic                   rx_valid,
  output logic                   received,
  output logic                   parity_error,
  output logic                   framing_error,
  output logic                   overrun,
  output logic                   Rx_error
);

  localparam int TW = $clog2(OVERSAMPLE + 1);
  localparam int BW = $clog2(WORD_LENGHT + 1);

  // Tick numbers inside one bit period (1..OVERSAMPLE) and the three
  // mid-bit sample points. The majority is decided at the last of the three.
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_S2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_LENGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } par_t;

  state_t state, next_state;

  logic                   rx_m, rx_s;
  logic                   armed;
  logic [DIV_WIDTH-1:0]   div_q;
  par_t                   par_q;
  logic                   two_q;
  logic [DIV_WIDTH-1:0]   presc;
  logic [TW-1:0]          tick_cnt;
  logic [TW-1:0]          tick_num;
  logic                   tick;
  logic                   decide;
  logic                   s0, s1;
  logic                   bit_val;
  logic                   start_det;
  logic                   par_en;
  logic [BW-1:0]          bit_cnt;
  logic [WORD_LENGHT-1:0] shreg;
  logic                   perr_p, ferr_p;
  logic                   keep;

  // Two-flop synchroniser. It resets to the idle line level so that reset
  // release never looks like a start bit.
  // NOTE: every clocked process uses non-blocking assignments, so all flops
  // update together and the order of statements cannot create races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX_in;
      rx_s <= rx_m;
    end
  end

  // Bit-timing helpers. The prescaler ticks only while a frame is active.
  assign tick      = (state != S_IDLE) && (state != S_DONE) && (presc == div_q);
  assign tick_num  = (tick_cnt == TICK_LAST) ? TW'(1) : tick_cnt + TW'(1);
  assign decide    = tick && (tick_num == TICK_S2);
  assign bit_val   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign start_det = (state == S_IDLE) && armed && !rx_s;
  assign par_en    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic. The state only advances on a bit decision, except for
  // the start detect and the single-cycle DONE state.
  // NOTE: next_state gets its default before the case statement, so every
  // path assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start_det) next_state = S_START;
      S_START:  if (decide) next_state = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (decide && (bit_cnt == BIT_LAST))
                  next_state = par_en ? S_PARITY : S_STOP1;
      S_PARITY: if (decide) next_state = S_STOP1;
      S_STOP1:  if (decide) next_state = two_q ? S_STOP2 : S_DONE;
      S_STOP2:  if (decide) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Receive datapath. This covers the prescaler, the tick counter, the
  // samples, the shift register, the latched configuration and the pending
  // errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      div_q    <= '0;
      par_q    <= PAR_NONE;
      two_q    <= 1'b0;
      presc    <= '0;
      tick_cnt <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr_p   <= 1'b0;
      ferr_p   <= 1'b0;
    end else begin
      // The prescaler is held in IDLE, so it restarts cleanly at start detect.
      if (state == S_IDLE) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        presc    <= '0;
        tick_cnt <= tick_num;
      end else begin
        presc    <= presc + DIV_WIDTH'(1);
      end

      if (tick && (tick_num == TICK_S0)) s0 <= rx_s;
      if (tick && (tick_num == TICK_S1)) s1 <= rx_s;

      // The line must be seen idle after each frame before the next start is
      // accepted. A held-low break therefore yields only one frame.
      if (state == S_DONE)                armed <= 1'b0;
      else if ((state == S_IDLE) && rx_s) armed <= 1'b1;

      if (start_det) begin
        div_q   <= baud_div;
        par_q   <= par_t'(parity_mode);
        two_q   <= two_stop;
        bit_cnt <= '0;
        perr_p  <= 1'b0;
        ferr_p  <= 1'b0;
      end

      if (decide) begin
        case (state)
          S_DATA: begin
            shreg   <= {bit_val, shreg[WORD_LENGHT-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
          end
          S_PARITY: begin
            if ((par_q == PAR_EVEN) && ((^shreg) ^ bit_val))  perr_p <= 1'b1;
            if ((par_q == PAR_ODD) && !((^shreg) ^ bit_val))  perr_p <= 1'b1;
          end
          S_STOP1, S_STOP2: if (!bit_val) ferr_p <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Host-visible outputs. If a clear arrives in the DONE cycle, the set still
  // wins, and overrun is judged against the received value before the clear.
  assign keep = !clear_interrupt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RX_out        <= '0;
      rx_valid      <= 1'b0;
      received      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      received      <= received & keep;
      parity_error  <= parity_error & keep;
      framing_error <= framing_error & keep;
      overrun       <= overrun & keep;
      if (state == S_DONE) begin
        RX_out        <= shreg;
        rx_valid      <= 1'b1;
        received      <= 1'b1;
        parity_error  <= (parity_error & keep) | perr_p;
        framing_error <= (framing_error & keep) | ferr_p;
        overrun       <= (overrun & keep) | received;
      end
    end
  end

  assign Rx_error = parity_error | framing_error | overrun;

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver: the next-generation serial receive block for the UART datapath. Takes the asynchronous serial line, synchronises it, times bits from a programmable oversample prescaler, and decides each bit by 3-sample majority vote. Supports runtime-selectable parity (none/even/odd) and one or two stop bits, and reports parity, framing and overrun errors separately. Sits between the pad-side RX line and the bus/interrupt logic that consumes received words.

## Interface
- WORD_LENGHT, 8, data bits per frame, 5..9
- OVERSAMPLE, 16, oversample ticks per bit, 4..32
- DIV_WIDTH, 16, width of `baud_div`
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- RX_in  input  1  asynchronous serial line, idle high
- baud_div  input  DIV_WIDTH  clk cycles per oversample tick minus 1; latched at start detect
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none; latched at start detect
- two_stop  input  1  1 = check two stop bits; latched at start detect
- clear_interrupt  input  1  synchronous clear of `received` and all error flags
- RX_out  output  WORD_LENGHT  last received word, LSB = first data bit
- rx_valid  output  1  one-clk pulse when `RX_out` updates
- received  output  1  sticky interrupt, set on every completed frame
- parity_error  output  1  sticky, set when the parity check fails
- framing_error  output  1  sticky, set when any stop bit is sampled 0
- overrun  output  1  sticky, set when a frame completes while `received` is already 1
- Rx_error  output  1  OR of the three error flags

## Operation
- Two-flop synchroniser on RX_in → `rx_s`. All decisions use `rx_s`.
- Prescaler counts 0..baud_div; tick when count == baud_div, so 1 tick per baud_div+1 clks. Held at 0 in IDLE and restarted at start detect.
- Within each bit period, ticks are numbered 1..OVERSAMPLE. With M = OVERSAMPLE/2, samples are taken at ticks M-1, M and M+1. The bit value is the majority of the three, decided at tick M+1. The next bit's tick 1 follows that bit's tick OVERSAMPLE.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE: armed only after `rx_s` has been seen high for at least 1 clk since the last frame. When armed and `rx_s` == 0, latch config, clear the prescaler and tick counter, go to START.
- START: if the majority is 1, treat it as a false start: go to IDLE with no outputs changed. Otherwise go to DATA.
- DATA: shift in WORD_LENGHT bits, LSB first. Then go to PARITY if parity is enabled, else STOP1.
- PARITY: even mode requires XOR(data, parity bit) == 0; odd mode requires it == 1. A mismatch marks a pending parity error.
- STOP1 → STOP2 if two_stop, else DONE. A stop sample of 0 marks a pending framing error. STOP2 follows the same rule.
- DONE (1 clk): update RX_out, pulse rx_valid, set received. OR the pending errors into their flags. Set overrun if received was already 1. Go to IDLE, disarmed.
- Data is always delivered; error frames still update RX_out.
- Overrun: the new word overwrites RX_out.
- clear_interrupt clears received and all error flags. If it arrives in the same clk as DONE, the set wins, and overrun evaluates against the pre-clear received value.
- baud_div, parity_mode and two_stop changes mid-frame have no effect until the next start detect.

## Timing
- Reset values: RX_out = 0, rx_valid = 0, received = 0, all error flags = 0, Rx_error = 0. FSM = IDLE, disarmed; synchroniser flops = 1.
- rst asserted mid-frame: all outputs go to reset values immediately (asynchronous). The frame in progress is discarded.
- RX_in to `rx_s`: 2 clks.
- Start detect to START: 1 clk.
- Stop decision tick to DONE: 1 clk. RX_out, rx_valid and the flags are visible the clk after DONE.
- The receiver returns to IDLE at mid-stop-bit, so back-to-back frames with no idle gap are received.
- Break (line held low): exactly one frame with framing_error. No further frames until the line goes high.

## Test plan
All tests use OVERSAMPLE = 16 and baud_div = 3 (4 clk/tick, 64 clk/bit).
- 8N1 frame 0xA5 → RX_out = 0xA5; rx_valid high for exactly 1 clk; received = 1; Rx_error = 0.
- Even parity, 0x3C sent with parity bit 1 → RX_out = 0x3C, parity_error = 1, Rx_error = 1. Same frame with parity bit 0 → no error.
- Line low for 20 clk, then high → no rx_valid, FSM back in IDLE. A following 0x5A frame is received correctly.
- Line low for 12 bit times, then high, then 0x11 frame → one frame 0x00 with framing_error = 1, then 0x11 received. No frames while the line stays low.
- Two frames 0x01, 0x02 with no clear → overrun = 1, RX_out = 0x02. A third frame 0x03 with clear_interrupt in its DONE clk → received = 1, RX_out = 0x03.
- rst pulsed during data bit 3 of a frame → outputs 0 immediately. The next full 0xC3 frame is received with no errors.
